serial_disp_rx: RTL
===================

Name: serial_disp_rx

Overview:
- Receiving end of the serial display/LED shift protocol driven by the 7-segment and LED drivers: clock line, data line, parallel-enable (latch) strobe, active-low clear.
- Oversamples the four lines on the system clock and deserializes each MSB-first frame. On the latch strobe it presents the frame as a parallel word.
- Used for on-board loopback checking and as the bench-side decoder for verifying the display drivers.

Parameters:
- WIDTH, 64, frame length in bits (64 for the 7-seg chain, 16 for the LED chain)
- CNT_W, 7, bit-counter width; must satisfy 2^CNT_W > WIDTH+1

Ports:
- clk  input  1  system clock (100 MHz)
- RSTN  input  1  asynchronous active-low reset
- s_clk  input  1  serial shift clock from driver (seg_clk/led_clk)
- s_din  input  1  serial data, MSB first (seg_sout/led_sout)
- s_pen  input  1  parallel-enable latch strobe, rising edge latches (SEG_PEN/LED_PEN)
- s_clrn  input  1  active-low clear (seg_clrn/led_clrn)
- data_out  output  WIDTH  last successfully latched frame
- data_valid  output  1  one-clk pulse when data_out updates
- bit_cnt  output  CNT_W  bits shifted since last latch or clear, saturating
- frame_err  output  1  sticky: latch seen with bit_cnt != WIDTH

Behaviour:
- Reset (RSTN low, async): sync flops are cleared to 0, except the s_clrn sync chain, which is set to 1. shift_reg = 0, bit_cnt = 0, data_out = 0, data_valid = 0, frame_err = 0, state = IDLE.
- Synchronization:
  - Each of s_clk, s_din, s_pen, s_clrn passes through a 2-flop synchronizer, plus a third flop for edge detection on s_clk and s_pen.
  - Each serial input's high and low times must be ≥3 clk cycles; faster inputs are out of spec.
- Shift:
  - On a detected rising edge of synced s_clk: shift_reg <= {shift_reg[WIDTH-2:0], din_sync}. Because s_din is synced with the same delay as s_clk, it is sampled aligned with the clock edge.
  - bit_cnt increments on each shift and saturates at WIDTH+1.
- State machine, derived from bit_cnt:
  - IDLE: cnt = 0.
  - SHIFT: 0 < cnt < WIDTH.
  - FULL: cnt = WIDTH.
  - OVER: cnt > WIDTH.
  - Transitions: a shift edge moves IDLE→SHIFT (or →FULL when WIDTH = 1), SHIFT→FULL at the WIDTH-th bit, and FULL→OVER on a further bit. OVER stays OVER on further bits.
- Latch:
  - On a detected rising edge of synced s_pen in FULL: data_out <= shift_reg, data_valid = 1 for exactly one cycle (registered, asserted the cycle after the edge is detected), then cnt → 0 (IDLE).
  - Latch edge in IDLE, SHIFT or OVER: data_out is unchanged, no data_valid, frame_err <= 1, cnt → 0.
  - frame_err clears only on RSTN.
- Same-cycle shift and latch edges: the shift is applied first. The latch uses the post-shift shift_reg and post-shift count.
- Clear: while synced s_clrn is low, shift_reg = 0 and bit_cnt = 0 (IDLE). s_clk and s_pen edges are ignored. data_out and frame_err hold.
- Clear and latch in the same cycle: clear wins, with no latch and no error.
- Shift register contents persist across latches. Only s_clrn or RSTN zero them.
- RSTN asserted mid-frame: everything returns to reset values immediately. Partial bits are discarded.

Test Plan:
- Reset, then shift 64 bits of 0x0123_4567_89AB_CDEF MSB first, then pulse s_pen → data_out = 0x0123456789ABCDEF, one data_valid pulse, bit_cnt = 0, frame_err = 0.
- Shift 63 bits, then pulse s_pen → data_out keeps its previous value, frame_err = 1, no data_valid, bit_cnt = 0. A following good 64-bit frame latches correctly and frame_err stays 1.
- Shift 66 bits (0b11 followed by 0xFFFF_0000_FFFF_0000) → bit_cnt saturates at 65, state OVER. s_pen → frame_err = 1, data_out unchanged.
- Shift 40 bits, drive s_clrn low for 10 clk cycles while toggling s_clk → bit_cnt = 0 and the shift register is 0. Release, shift 64 bits of 0xA5A5_A5A5_5A5A_5A5A, latch → data_out = 0xA5A5A5A55A5A5A5A.
- WIDTH = 16: shift 0xBEEF, with the 16th s_clk rising edge coincident with the s_pen rising edge → data_out = 0xBEEF, data_valid pulses, frame_err = 0.
- Deassert RSTN after 30 bits of a frame → all outputs are 0 immediately. After release, a clean 64-bit frame of 0xFFFF_FFFF_FFFF_FFFF latches correctly.

Source files
------------

// File: rtl/serial_disp_rx.sv
// Receiver for the serial display/LED shift chain.
// Oversamples clk/data/latch/clear and presents latched frames.
module serial_disp_rx #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             s_clk,
  input  logic             s_din,
  input  logic             s_pen,
  input  logic             s_clrn,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_err
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FULL,
    OVER
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2:0] sclk_q;
  logic [1:0] sdin_q;
  logic [2:0] spen_q;
  logic [1:0] sclrn_q;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  state_t           state_q, state_d;

  logic             clk_rise;
  logic             pen_rise;
  logic             din_s;
  logic             clrn_s;
  logic [WIDTH:0]   ext;
  state_t           post_st;

  assign clk_rise = sclk_q[1] & ~sclk_q[2];
  assign pen_rise = spen_q[1] & ~spen_q[2];
  assign din_s    = sdin_q[1];
  assign clrn_s   = sclrn_q[1];
  assign ext      = {shift_q, din_s};

  // Two-flop synchronizers; third stage on clk/pen for edges.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sclk_q  <= '0;
      sdin_q  <= '0;
      spen_q  <= '0;
      sclrn_q <= '1;
    end else begin
      sclk_q  <= {sclk_q[1:0], s_clk};
      sdin_q  <= {sdin_q[0], s_din};
      spen_q  <= {spen_q[1:0], s_pen};
      sclrn_q <= {sclrn_q[0], s_clrn};
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Shift first, then latch against the post-shift state.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = err_q;
    state_d = state_q;
    post_st = state_q;
    if (!clrn_s) begin
      shift_d = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      if (clk_rise) begin
        shift_d = ext[WIDTH-1:0];
        if (state_q != OVER) begin
          cnt_d = cnt_q + 1'b1;
        end
        unique case (state_q)
          IDLE:    post_st = (WIDTH == 1) ? FULL : SHIFT;
          SHIFT:   post_st = (cnt_q == CNT_LAST) ? FULL : SHIFT;
          FULL:    post_st = OVER;
          OVER:    post_st = OVER;
          default: post_st = IDLE;
        endcase
      end
      state_d = post_st;
      if (pen_rise) begin
        if (post_st == FULL) begin
          dout_d  = shift_d;
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        cnt_d   = '0;
        state_d = IDLE;
      end
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign frame_err  = err_q;

endmodule
